// File: rtl/n_set_cache_miss_sequencer.sv
// Miss sequencer for the n-set cache: victim request, metadata read, optional write-back, fetch, commit.
// Define N_SET_CACHE_MISS_SEQ_PERF_EN to add saturating miss / write-back counters.
module n_set_cache_miss_sequencer #(
  parameter int CACHE_BLOCK_CAPACITY = 128,
  parameter int CACHE_SET_SIZE       = 4,
  parameter int BW_TAG               = 20,
  parameter int CACHE_BLOCK_WORDS    = 4,
  parameter int BW_CACHE_CAPACITY    = $clog2(CACHE_BLOCK_CAPACITY),
  parameter int BW_GRP               = $clog2(CACHE_SET_SIZE),
  parameter int BW_SET               = BW_CACHE_CAPACITY - BW_GRP,
  parameter int BW_WORD              = (CACHE_BLOCK_WORDS > 1) ? $clog2(CACHE_BLOCK_WORDS) : 1
) (
  input  logic                         clock_i,
  input  logic                         resetn_i,
  input  logic                         req_i,
  input  logic [BW_SET-1:0]            req_set_i,
  input  logic [BW_TAG-1:0]            req_tag_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         policy_miss_o,
  output logic                         policy_hit_o,
  output logic [BW_CACHE_CAPACITY-1:0] policy_addr_o,
  input  logic                         policy_done_i,
  input  logic [BW_CACHE_CAPACITY-1:0] policy_addr_i,
  output logic [BW_CACHE_CAPACITY-1:0] meta_addr_o,
  input  logic                         meta_valid_i,
  input  logic                         meta_dirty_i,
  input  logic [BW_TAG-1:0]            meta_tag_i,
  output logic                         meta_we_o,
  output logic [BW_TAG-1:0]            meta_tag_o,
  output logic                         mem_req_o,
  output logic                         mem_rw_o,
  output logic [BW_TAG+BW_SET-1:0]     mem_addr_o,
  output logic [BW_WORD-1:0]           mem_word_o,
  input  logic                         mem_ack_i
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
  ,
  output logic [31:0]                  miss_count_o,
  output logic [31:0]                  wb_count_o
`endif
);

  localparam logic [BW_WORD-1:0] LAST_WORD = BW_WORD'(CACHE_BLOCK_WORDS - 1);

  // S_WBGAP is the single idle memory cycle separating the write-back burst from the fetch burst
  typedef enum logic [2:0] {
    S_IDLE,
    S_POLICY,
    S_META,
    S_WB,
    S_WBGAP,
    S_FETCH,
    S_COMMIT
  } state_t;

  state_t                         r_state;
  state_t                         w_nextState;
  logic [BW_SET-1:0]              r_set;
  logic [BW_TAG-1:0]              r_tag;
  logic [BW_CACHE_CAPACITY-1:0]   r_victim;
  logic [BW_TAG-1:0]              r_victimTag;
  logic [BW_WORD-1:0]             r_word;
  logic                           r_metaPhase;
  logic                           w_lastWord;

  assign w_lastWord = (r_word == LAST_WORD);

  always_comb begin
    w_nextState   = r_state;
    busy_o        = (r_state != S_IDLE);
    done_o        = 1'b0;
    policy_miss_o = 1'b0;
    policy_hit_o  = 1'b0;
    policy_addr_o = '0;
    meta_addr_o   = '0;
    meta_we_o     = 1'b0;
    meta_tag_o    = '0;
    mem_req_o     = 1'b0;
    mem_rw_o      = 1'b0;
    mem_addr_o    = '0;
    mem_word_o    = '0;
    case (r_state)
      S_IDLE: begin
        if (req_i) w_nextState = S_POLICY;
      end
      S_POLICY: begin
        policy_miss_o = 1'b1;
        policy_addr_o = {{BW_GRP{1'b0}}, r_set};
        if (policy_done_i) w_nextState = S_META;
      end
      S_META: begin
        meta_addr_o = r_victim;
        // Metadata arrives one cycle after the address, so decide only in the second META cycle
        if (r_metaPhase) begin
          w_nextState = (meta_valid_i && meta_dirty_i) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        mem_req_o  = 1'b1;
        mem_rw_o   = 1'b1;
        mem_addr_o = {r_victimTag, r_set};
        mem_word_o = r_word;
        if (mem_ack_i && w_lastWord) w_nextState = S_WBGAP;
      end
      S_WBGAP: begin
        w_nextState = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {r_tag, r_set};
        mem_word_o = r_word;
        if (mem_ack_i && w_lastWord) w_nextState = S_COMMIT;
      end
      S_COMMIT: begin
        meta_we_o     = 1'b1;
        meta_addr_o   = r_victim;
        meta_tag_o    = r_tag;
        policy_hit_o  = 1'b1;
        policy_addr_o = r_victim;
        done_o        = 1'b1;
        w_nextState   = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state     <= S_IDLE;
      r_set       <= '0;
      r_tag       <= '0;
      r_victim    <= '0;
      r_victimTag <= '0;
      r_word      <= '0;
      r_metaPhase <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_set <= req_set_i;
            r_tag <= req_tag_i;
          end
        end
        S_POLICY: begin
          if (policy_done_i) r_victim <= policy_addr_i;
        end
        S_META: begin
          r_metaPhase <= ~r_metaPhase;
          if (r_metaPhase) r_victimTag <= meta_tag_i;
        end
        S_WB, S_FETCH: begin
          if (mem_ack_i) r_word <= w_lastWord ? '0 : r_word + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
  logic [31:0] r_missCount;
  logic [31:0] r_wbCount;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_missCount <= '0;
      r_wbCount   <= '0;
    end else begin
      if (r_state == S_COMMIT && r_missCount != 32'hFFFF_FFFF) r_missCount <= r_missCount + 32'd1;
      if (r_state == S_WB && w_nextState == S_WBGAP && r_wbCount != 32'hFFFF_FFFF)
        r_wbCount <= r_wbCount + 32'd1;
    end
  end

  assign miss_count_o = r_missCount;
  assign wb_count_o   = r_wbCount;
`endif

endmodule

// File: tb/tb_n_set_cache_miss_sequencer.sv
// Self-checking bench for n_set_cache_miss_sequencer; memory beats are scoreboarded through a queue.
// Perf counter checks are compiled in when N_SET_CACHE_MISS_SEQ_PERF_EN is defined.
module tb_n_set_cache_miss_sequencer;

  localparam int BW_CACHE = 7;
  localparam int BW_SET   = 5;
  localparam int BW_TAG   = 20;
  localparam int BW_WORD  = 2;
  localparam int WORDS    = 4;
  localparam int BW_ADDR  = BW_TAG + BW_SET;

  logic                clock_i = 1'b0;
  logic                resetn_i = 1'b1;
  logic                req_i = 1'b0;
  logic [BW_SET-1:0]   req_set_i = '0;
  logic [BW_TAG-1:0]   req_tag_i = '0;
  logic                busy_o;
  logic                done_o;
  logic                policy_miss_o;
  logic                policy_hit_o;
  logic [BW_CACHE-1:0] policy_addr_o;
  logic                policy_done_i = 1'b0;
  logic [BW_CACHE-1:0] policy_addr_i = '0;
  logic [BW_CACHE-1:0] meta_addr_o;
  logic                meta_valid_i = 1'b0;
  logic                meta_dirty_i = 1'b0;
  logic [BW_TAG-1:0]   meta_tag_i = '0;
  logic                meta_we_o;
  logic [BW_TAG-1:0]   meta_tag_o;
  logic                mem_req_o;
  logic                mem_rw_o;
  logic [BW_ADDR-1:0]  mem_addr_o;
  logic [BW_WORD-1:0]  mem_word_o;
  logic                mem_ack_i = 1'b0;
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
  logic [31:0]         miss_count_o;
  logic [31:0]         wb_count_o;
`endif

  typedef struct {
    logic               rw;
    logic [BW_ADDR-1:0] addr;
    logic [BW_WORD-1:0] word;
  } beat_t;

  beat_t expQ[$];
  int    testsRun    = 0;
  int    testsFailed = 0;

  n_set_cache_miss_sequencer dut (
    .clock_i       (clock_i),
    .resetn_i      (resetn_i),
    .req_i         (req_i),
    .req_set_i     (req_set_i),
    .req_tag_i     (req_tag_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .policy_miss_o (policy_miss_o),
    .policy_hit_o  (policy_hit_o),
    .policy_addr_o (policy_addr_o),
    .policy_done_i (policy_done_i),
    .policy_addr_i (policy_addr_i),
    .meta_addr_o   (meta_addr_o),
    .meta_valid_i  (meta_valid_i),
    .meta_dirty_i  (meta_dirty_i),
    .meta_tag_i    (meta_tag_i),
    .meta_we_o     (meta_we_o),
    .meta_tag_o    (meta_tag_o),
    .mem_req_o     (mem_req_o),
    .mem_rw_o      (mem_rw_o),
    .mem_addr_o    (mem_addr_o),
    .mem_word_o    (mem_word_o),
    .mem_ack_i     (mem_ack_i)
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
    ,
    .miss_count_o  (miss_count_o),
    .wb_count_o    (wb_count_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  task automatic applyReset();
    resetn_i      = 1'b0;
    req_i         = 1'b0;
    policy_done_i = 1'b0;
    mem_ack_i     = 1'b0;
    repeat (2) @(negedge clock_i);
    resetn_i = 1'b1;
    @(negedge clock_i);
  endtask

  // Drives one miss and plays policy, metadata and memory. Inputs are driven and outputs
  // sampled on the falling edge; metadata is only correct during the second META cycle.
  task automatic run_miss(input logic [BW_SET-1:0] set, input logic [BW_TAG-1:0] tag,
                          input logic [BW_CACHE-1:0] victim, input logic mValid,
                          input logic mDirty, input logic [BW_TAG-1:0] mTag,
                          input int stall, input bit memWaits, input int abortAfter,
                          input bit keepReq, output int cycles, output int polCycles,
                          output int wbBeats, output bit aborted);
    int    fetchAcks = 0;
    int    metaCyc   = 0;
    bit    doneSeen  = 0;
    bit    prevReq   = 0;
    bit    prevRw    = 0;
    beat_t b;
    cycles = 0; polCycles = 0; wbBeats = 0; aborted = 0;
    expQ.delete();
    if (mValid && mDirty)
      for (int w = 0; w < WORDS; w++) begin
        b.rw = 1'b1; b.addr = {mTag, set}; b.word = BW_WORD'(w); expQ.push_back(b);
      end
    for (int w = 0; w < WORDS; w++) begin
      b.rw = 1'b0; b.addr = {tag, set}; b.word = BW_WORD'(w); expQ.push_back(b);
    end
    req_i = 1'b1; req_set_i = set; req_tag_i = tag;
    policy_done_i = 1'b0; policy_addr_i = ~victim; mem_ack_i = 1'b0;
    meta_valid_i = ~mValid; meta_dirty_i = ~mDirty; meta_tag_i = ~mTag;
    while (!doneSeen && cycles < 300) begin
      @(negedge clock_i);
      cycles++;
      if (abortAfter >= 0 && fetchAcks == abortAfter) begin
        mem_ack_i = 1'b0; req_i = 1'b0;
        #2 resetn_i = 1'b0;
        #1 aborted = 1;
        break;
      end
      if (policy_miss_o) begin
        polCycles++;
        testsRun++;
        if (policy_addr_o !== {2'b00, set} || mem_req_o !== 1'b0 || meta_we_o !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL policy_phase: addr=%h mem_req=%b meta_we=%b, expected addr=%h mem_req=0 meta_we=0",
                   policy_addr_o, mem_req_o, meta_we_o, {2'b00, set});
        end
        policy_done_i = (polCycles > stall);
        policy_addr_i = policy_done_i ? victim : ~victim;
      end else begin
        policy_done_i = 1'b0;
        policy_addr_i = ~victim;
      end
      if (busy_o && !policy_miss_o && !mem_req_o && !meta_we_o && meta_addr_o == victim) metaCyc++;
      if (metaCyc == 2 && busy_o && !mem_req_o && !meta_we_o && meta_addr_o == victim) begin
        meta_valid_i = mValid; meta_dirty_i = mDirty; meta_tag_i = mTag;
      end else begin
        meta_valid_i = ~mValid; meta_dirty_i = ~mDirty; meta_tag_i = ~mTag;
      end
      mem_ack_i = 1'b0;
      if (mem_req_o && prevReq) begin
        testsRun++;
        if (mem_rw_o !== prevRw) begin
          testsFailed++;
          $display("[TB] FAIL burst_gap: rw changed %b->%b with mem_req held, expected one idle cycle",
                   prevRw, mem_rw_o);
        end
      end
      if (mem_req_o && (!memWaits || $urandom_range(0, 2) != 0)) begin
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL mem_beat: unexpected beat rw=%b addr=%h word=%0d, expected none",
                   mem_rw_o, mem_addr_o, mem_word_o);
        end else begin
          b = expQ.pop_front();
          if (mem_rw_o !== b.rw || mem_addr_o !== b.addr || mem_word_o !== b.word) begin
            testsFailed++;
            $display("[TB] FAIL mem_beat: rw=%b addr=%h word=%0d, expected rw=%b addr=%h word=%0d",
                     mem_rw_o, mem_addr_o, mem_word_o, b.rw, b.addr, b.word);
          end
          if (b.rw) wbBeats++;
          else fetchAcks++;
        end
        mem_ack_i = 1'b1;
      end
      prevReq = mem_req_o;
      prevRw  = mem_rw_o;
      if (done_o) begin
        doneSeen = 1;
        testsRun++;
        if (meta_we_o !== 1'b1 || meta_addr_o !== victim || meta_tag_o !== tag ||
            policy_hit_o !== 1'b1 || policy_addr_o !== victim || expQ.size() != 0) begin
          testsFailed++;
          $display("[TB] FAIL commit: we=%b maddr=%h mtag=%h hit=%b paddr=%h left=%0d, expected we=1 maddr=%h mtag=%h hit=1 paddr=%h left=0",
                   meta_we_o, meta_addr_o, meta_tag_o, policy_hit_o, policy_addr_o, expQ.size(),
                   victim, tag, victim);
        end
        if (!keepReq) req_i = 1'b0;
      end else begin
        testsRun++;
        if (meta_we_o !== 1'b0 || policy_hit_o !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL early_commit: meta_we=%b policy_hit=%b before done, expected 0 0",
                   meta_we_o, policy_hit_o);
        end
      end
    end
    if (!aborted) begin
      if (!doneSeen) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL done_timeout: no done_o after %0d cycles, expected done", cycles);
      end else begin
        @(negedge clock_i);
        mem_ack_i = 1'b0;
        testsRun++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL done_pulse: done=%b busy=%b after commit, expected 0 0", done_o, busy_o);
        end
      end
    end
  endtask

  task automatic test_reset();
    applyReset();
    testsRun++;
    if ({busy_o, done_o, policy_miss_o, policy_hit_o, meta_we_o, mem_req_o, mem_rw_o} !== 7'b0 ||
        policy_addr_o !== '0 || meta_addr_o !== '0 || meta_tag_o !== '0 ||
        mem_addr_o !== '0 || mem_word_o !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b pmiss=%b phit=%b we=%b req=%b paddr=%h maddr=%h memaddr=%h word=%0d, expected all 0",
               busy_o, done_o, policy_miss_o, policy_hit_o, meta_we_o, mem_req_o,
               policy_addr_o, meta_addr_o, mem_addr_o, mem_word_o);
    end
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
    testsRun++;
    if (miss_count_o !== 32'd0 || wb_count_o !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_counters: miss=%0d wb=%0d, expected 0 0", miss_count_o, wb_count_o);
    end
`endif
  endtask

  task automatic test_clean();
    int cyc, pol, wb;
    bit ab;
    run_miss(5'd3, 20'h00ABC, 7'h43, 1'b1, 1'b0, 20'h00777, 0, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (wb != 0 || cyc != 8 || pol != 1) begin
      testsFailed++;
      $display("[TB] FAIL clean_latency: wb=%0d cycles=%0d policy=%0d, expected 0 8 1", wb, cyc, pol);
    end
    run_miss(5'd31, 20'hFFFFF, 7'h7F, 1'b1, 1'b0, 20'h0000F, 0, 1'b1, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (wb != 0) begin
      testsFailed++;
      $display("[TB] FAIL clean_waits: wb beats=%0d, expected 0", wb);
    end
  endtask

  task automatic test_dirty();
    int cyc, pol, wb;
    bit ab;
    run_miss(5'd9, 20'h0BEEF, 7'h2A, 1'b1, 1'b1, 20'h00123, 0, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (wb != WORDS || cyc != 13) begin
      testsFailed++;
      $display("[TB] FAIL dirty_latency: wb=%0d cycles=%0d, expected %0d 13", wb, cyc, WORDS);
    end
    run_miss(5'd0, 20'h12345, 7'h01, 1'b1, 1'b1, 20'hABCDE, 0, 1'b1, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (wb != WORDS) begin
      testsFailed++;
      $display("[TB] FAIL dirty_waits: wb beats=%0d, expected %0d", wb, WORDS);
    end
  endtask

  task automatic test_invalid_dirty();
    int cyc, pol, wb;
    bit ab;
    run_miss(5'd17, 20'h55555, 7'h51, 1'b0, 1'b1, 20'h99999, 0, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (wb != 0 || cyc != 8) begin
      testsFailed++;
      $display("[TB] FAIL invalid_dirty: wb=%0d cycles=%0d, expected 0 8", wb, cyc);
    end
  endtask

  task automatic test_policy_stall();
    int cyc, pol, wb;
    bit ab;
    run_miss(5'd12, 20'h0F0F0, 7'h6C, 1'b1, 1'b0, 20'h00001, 5, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (pol != 6 || cyc != 13) begin
      testsFailed++;
      $display("[TB] FAIL policy_stall: policy cycles=%0d total=%0d, expected 6 13", pol, cyc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int cyc, pol, wb;
    bit ab;
    run_miss(5'd7, 20'h5A5A5, 7'h12, 1'b1, 1'b0, 20'h00002, 0, 1'b0, 2, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (!ab || {busy_o, done_o, policy_miss_o, policy_hit_o, meta_we_o, mem_req_o, mem_rw_o} !== 7'b0 ||
        mem_addr_o !== '0 || mem_word_o !== '0 || meta_addr_o !== '0 || policy_addr_o !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: aborted=%b busy=%b req=%b we=%b memaddr=%h word=%0d, expected aborted=1 and all 0",
               ab, busy_o, mem_req_o, meta_we_o, mem_addr_o, mem_word_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      testsRun++;
      if (meta_we_o !== 1'b0 || busy_o !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold: meta_we=%b busy=%b, expected 0 0", meta_we_o, busy_o);
      end
    end
    #2 resetn_i = 1'b1;
    @(negedge clock_i);
    run_miss(5'd7, 20'h5A5A5, 7'h12, 1'b1, 1'b0, 20'h00002, 0, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (cyc != 8 || pol != 1) begin
      testsFailed++;
      $display("[TB] FAIL restart: cycles=%0d policy=%0d, expected 8 1", cyc, pol);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, pol, wb;
    bit ab;
    run_miss(5'd1, 20'h11111, 7'h21, 1'b1, 1'b0, 20'h0, 0, 1'b0, -1, 1'b1, cyc, pol, wb, ab);
    run_miss(5'd2, 20'h22222, 7'h42, 1'b1, 1'b1, 20'h33333, 0, 1'b0, -1, 1'b1, cyc, pol, wb, ab);
    testsRun++;
    if (cyc != 13 || wb != WORDS) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_dirty: cycles=%0d wb=%0d, expected 13 %0d", cyc, wb, WORDS);
    end
    run_miss(5'd4, 20'h44444, 7'h64, 1'b0, 1'b0, 20'h0, 0, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (cyc != 8 || wb != 0) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_clean: cycles=%0d wb=%0d, expected 8 0", cyc, wb);
    end
  endtask

`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
  task automatic test_perf();
    int cyc, pol, wb;
    bit ab;
    applyReset();
    run_miss(5'd3, 20'h00ABC, 7'h43, 1'b1, 1'b0, 20'h0, 0, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    run_miss(5'd5, 20'h00DEF, 7'h25, 1'b1, 1'b1, 20'h00123, 0, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    run_miss(5'd6, 20'h00FED, 7'h46, 1'b0, 1'b1, 20'h00456, 0, 1'b0, -1, 1'b0, cyc, pol, wb, ab);
    testsRun++;
    if (miss_count_o !== 32'd3 || wb_count_o !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL perf_counters: miss=%0d wb=%0d, expected 3 1", miss_count_o, wb_count_o);
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_clean();
    test_dirty();
    test_invalid_dirty();
    test_policy_stall();
    test_reset_mid_fetch();
    test_back_to_back();
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
